project: RTL and testbench

PROJECT -- requirements
Module: project

---
 rtl/project.sv | 206 ++++++++++++++++++++
 tb/tb_project.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/project.sv
// UART-fed signed matrix-vector multiplier: receives the k matrix and x vector
// over RX, computes y = k*x and transmits each y element back as one UART frame.
module project #(
  parameter int R                = 2,
  parameter int C                = 2,
  parameter int W_X              = 4,
  parameter int W_K              = 2,
  parameter int W_Y_OUT          = 8,
  parameter int CLOCKS_PER_PULSE = 2604,
  parameter int BITS_PER_WORD    = 8,
  parameter int PACKET_SIZE_TX   = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int N_WORDS_KX = (R*C*W_K + C*W_X) / BITS_PER_WORD;
  localparam int KX_W       = N_WORDS_KX * BITS_PER_WORD;
  localparam int W_P        = W_X + W_K;
  localparam int W_Y        = W_X + W_K + $clog2(C);
  localparam int CW         = $clog2(CLOCKS_PER_PULSE);
  localparam int BCW        = (N_WORDS_KX > 1) ? $clog2(N_WORDS_KX) : 1;
  localparam int RBW        = $clog2(BITS_PER_WORD);
  localparam int TBW        = $clog2(PACKET_SIZE_TX);
  localparam int RW         = (R > 1) ? $clog2(R) : 1;
  localparam int PAD        = PACKET_SIZE_TX - BITS_PER_WORD - 1;

  localparam logic [CW-1:0]  HALF      = CW'(CLOCKS_PER_PULSE/2 - 1);
  localparam logic [CW-1:0]  FULL      = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [RBW-1:0] LAST_BIT  = RBW'(BITS_PER_WORD - 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(N_WORDS_KX - 1);
  localparam logic [TBW-1:0] LAST_PKT  = TBW'(PACKET_SIZE_TX - 1);
  localparam logic [RW-1:0]  LAST_WORD = RW'(R - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic                     rx_s1, rx_s2;
  logic [1:0]               rx_state;
  logic [CW-1:0]            rx_cnt;
  logic [RBW-1:0]           rx_bit;
  logic [BITS_PER_WORD-1:0] rx_shift;
  logic [BCW-1:0]           byte_cnt;
  logic [KX_W-1:0]          kx;
  logic                     kx_valid;

  logic [R*W_Y_OUT-1:0]     y_comb, y_word;
  logic                     y_valid;
  logic signed [W_X-1:0]    xv;
  logic signed [W_K-1:0]    kv;
  logic signed [W_P-1:0]    prod;
  logic signed [W_Y-1:0]    acc;

  logic                     tx_busy;
  logic [R*W_Y_OUT-1:0]     tx_buf;
  logic [RW-1:0]            tx_word_idx;
  logic [TBW-1:0]           tx_bit;
  logic [CW-1:0]            tx_cnt;
  logic                     pend_valid;
  logic [R*W_Y_OUT-1:0]     pend_data;
  logic [W_Y_OUT-1:0]       tx_word;
  logic [PACKET_SIZE_TX-1:0] frame;
  logic                     tx_line;
  logic                     unused_ok;

  // Receiver: rx is resynchronised, then sampled mid-bit; a byte is kept only with a good stop bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      byte_cnt <= '0;
      kx       <= '0;
      kx_valid <= 1'b0;
    end else begin
      rx_s1    <= ui_in[0];
      rx_s2    <= rx_s1;
      kx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (!rx_s2) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF) begin
            rx_cnt   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        RX_DATA: begin
          if (rx_cnt == FULL) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[BITS_PER_WORD-1:1]};
            if (rx_bit == LAST_BIT) rx_state <= RX_STOP;
            else rx_bit <= rx_bit + 1'b1;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        RX_STOP: begin
          if (rx_cnt == FULL) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              kx[byte_cnt*BITS_PER_WORD +: BITS_PER_WORD] <= rx_shift;
              if (byte_cnt == LAST_BYTE) begin
                byte_cnt <= '0;
                kx_valid <= 1'b1;
              end else byte_cnt <= byte_cnt + 1'b1;
            end
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Full-width signed dot products, each sign-extended into its own output word.
  always_comb begin
    y_comb = '0;
    xv     = '0;
    kv     = '0;
    prod   = '0;
    acc    = '0;
    for (int r = 0; r < R; r++) begin
      acc = '0;
      for (int c = 0; c < C; c++) begin
        xv   = kx[W_X*c +: W_X];
        kv   = kx[C*W_X + W_K*(r*C + c) +: W_K];
        prod = W_P'(kv) * W_P'(xv);
        acc  = acc + W_Y'(prod);
      end
      y_comb[r*W_Y_OUT +: W_Y_OUT] = W_Y_OUT'(acc);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_valid <= 1'b0;
      y_word  <= '0;
    end else begin
      y_valid <= kx_valid;
      if (kx_valid) y_word <= y_comb;
    end
  end

  // Transmitter with a single pending slot; an idle transmitter drains the slot before new results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_busy     <= 1'b0;
      tx_buf      <= '0;
      tx_word_idx <= '0;
      tx_bit      <= '0;
      tx_cnt      <= '0;
      pend_valid  <= 1'b0;
      pend_data   <= '0;
    end else begin
      if (tx_busy) begin
        if (tx_cnt == FULL) begin
          tx_cnt <= '0;
          if (tx_bit == LAST_PKT) begin
            tx_bit <= '0;
            if (tx_word_idx == LAST_WORD) begin
              tx_word_idx <= '0;
              tx_busy     <= 1'b0;
            end else tx_word_idx <= tx_word_idx + 1'b1;
          end else tx_bit <= tx_bit + 1'b1;
        end else tx_cnt <= tx_cnt + 1'b1;
      end
      if (!tx_busy && pend_valid) begin
        tx_busy    <= 1'b1;
        tx_buf     <= pend_data;
        pend_valid <= y_valid;
        if (y_valid) pend_data <= y_word;
      end else if (!tx_busy && y_valid) begin
        tx_busy <= 1'b1;
        tx_buf  <= y_word;
      end else if (y_valid && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_data  <= y_word;
      end
    end
  end

  always_comb begin
    tx_word = tx_buf[tx_word_idx*W_Y_OUT +: W_Y_OUT];
    frame   = {{PAD{1'b1}}, tx_word[BITS_PER_WORD-1:0], 1'b0};
    tx_line = tx_busy ? frame[tx_bit] : 1'b1;
  end

  assign uo_out    = {7'b0, tx_line};
  assign uio_out   = 8'b0;
  assign uio_oe    = 8'b0;
  assign unused_ok = &{1'b0, ena, ui_in[7:1], uio_in};

endmodule

// File: tb/tb_project.sv
// Bench for project: drives UART sets into rx, decodes tx frames and compares
// them with an arithmetic model of the matrix-vector product.
module tb_project;

  localparam int CPP = 16;
  localparam int PAD = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena   = 1'b1;
  logic [7:0] ui_in = 8'h01;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  logic mon_busy = 1'b0;
  logic rst_seen = 1'b1;

  project #(.CLOCKS_PER_PULSE(CPP)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_seen <= rst_n;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic int sx(input logic [3:0] v);
    return (v >= 4'd8) ? int'(v) - 16 : int'(v);
  endfunction

  function automatic int sk(input logic [1:0] v);
    return v[1] ? int'(v) - 4 : int'(v);
  endfunction

  // Model: y[r] = sum_c k[r][c]*x[c] with plain integers, low byte transmitted.
  task automatic model_push(input logic [7:0] b0, input logic [7:0] b1);
    int x0, x1, y0, y1;
    x0 = sx(b0[3:0]);
    x1 = sx(b0[7:4]);
    y0 = sk(b1[1:0]) * x0 + sk(b1[3:2]) * x1;
    y1 = sk(b1[5:4]) * x0 + sk(b1[7:6]) * x1;
    exp_q.push_back(8'(y0));
    exp_q.push_back(8'(y1));
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ui_in[0] = 1'b0;
    repeat (CPP) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ui_in[0] = b[i];
      repeat (CPP) @(negedge clk);
    end
    ui_in[0] = 1'b1;
    repeat (CPP + 2) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [7:0] b0, input logic [7:0] b1);
    model_push(b0, b1);
    send_byte(b0);
    send_byte(b1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_val({name, "_drain"}, 32'(n < 5000), 32'd1);
    exp_q.delete();
    repeat (2 * CPP) @(negedge clk);
  endtask

  task automatic check_output(input int pos, input logic [7:0] e0, input logic [7:0] e1);
    check_val("log_len", 32'(rx_log.size() >= pos + 2), 32'd1);
    if (rx_log.size() >= pos + 2) begin
      check_val("y0_literal", 32'(rx_log[pos]), 32'(e0));
      check_val("y1_literal", 32'(rx_log[pos+1]), 32'(e1));
    end
  endtask

  // Frame decoder on tx: start bit low, 8 data bits LSB first, PAD high bits.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n && uo_out[0] == 1'b0) begin
        mon_busy = 1'b1;
        repeat (CPP/2) @(negedge clk);
        check_val("start_bit", 32'(uo_out[0]), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPP) @(negedge clk);
          b[i] = uo_out[0];
        end
        for (int i = 0; i < PAD; i++) begin
          repeat (CPP) @(negedge clk);
          check_val("pad_bit", 32'(uo_out[0]), 32'd1);
        end
        rx_log.push_back(b);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_frame: actual=0x%0h required=none", b);
        end else begin
          check_val("tx_byte", 32'(b), 32'(exp_q.pop_front()));
        end
        mon_busy = 1'b0;
      end
    end
  end

  // Per-cycle checks of constant outputs and the idle-high line under reset.
  initial begin
    forever begin
      @(negedge clk);
      check_val("static_outputs", 32'({uo_out[7:1], uio_out, uio_oe}), 32'd0);
      if (rst_seen === 1'b0) check_val("tx_in_reset", 32'(uo_out[0]), 32'd1);
    end
  end

  initial begin
    int base;
    repeat (4) @(negedge clk);
    check_val("reset_uo_out", 32'(uo_out), 32'h01);
    check_val("reset_uio_out", 32'(uio_out), 32'h00);
    check_val("reset_uio_oe", 32'(uio_oe), 32'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_val("idle_tx", 32'(uo_out[0]), 32'd1);

    $display("[TB] set x=1,2 k=1");
    base = rx_log.size();
    apply_stimulus(8'h21, 8'h55);
    wait_drain("set1");
    check_output(base, 8'h03, 8'h03);

    $display("[TB] set x=7,7 k=-1");
    base = rx_log.size();
    apply_stimulus(8'h77, 8'hFF);
    wait_drain("set2");
    check_output(base, 8'hF2, 8'hF2);

    $display("[TB] set x=-8,-8 k=-2");
    base = rx_log.size();
    apply_stimulus(8'h88, 8'hAA);
    wait_drain("set3");
    check_output(base, 8'h20, 8'h20);

    // k01 bits are 2'b10, which is -2 as a signed 2-bit value: y0 = -1 - 6 = -7.
    $display("[TB] set x=-1,3 k=1,-2,0,0");
    base = rx_log.size();
    apply_stimulus(8'h3F, 8'h09);
    wait_drain("set4");
    check_output(base, 8'hF9, 8'h00);

    $display("[TB] back-to-back sets");
    base = rx_log.size();
    apply_stimulus(8'h21, 8'h55);
    apply_stimulus(8'h77, 8'hFF);
    wait_drain("b2b");
    check_output(base, 8'h03, 8'h03);
    check_output(base + 2, 8'hF2, 8'hF2);

    $display("[TB] reset in the middle of an rx byte");
    base = rx_log.size();
    send_byte(8'h77);
    ui_in[0] = 1'b0;
    repeat (CPP) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ui_in[0] = 1'(8'hFF >> i);
      repeat (CPP) @(negedge clk);
    end
    rst_n    = 1'b0;
    ui_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_val("tx_after_reset", 32'(uo_out[0]), 32'd1);
    apply_stimulus(8'h88, 8'hAA);
    wait_drain("after_reset");
    check_output(base, 8'h20, 8'h20);

    repeat (4 * CPP * 13) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
